sb_transactions_rx_fsm: RTL and testbench

Sideband receive-side transaction parser. It takes 10-bit deserialized SB symbols from the RX deserializer. It decodes LT transactions (DLE, LSE, CLSE) and AT transactions (DLE, STX, payload, CRC, DLE, ETX), checks the CRC-16, and presents decoded fields to the control unit. It is the counterpart of the SB transactions generator: any frame that block emits must decode here without error.

---
 rtl/sb_transactions_rx_fsm_if.sv | 32 +++
 rtl/sb_transactions_rx_fsm.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_sb_transactions_rx_fsm.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_transactions_rx_fsm_if.sv
// Sideband RX parser bus: symbol input strobe plus decoded transaction outputs.
interface sb_transactions_rx_fsm_if #(
  parameter int MAX_LEN = 3
);
  logic [9:0]           symbol;
  logic                 symbol_valid;
  logic                 lt_received;
  logic [7:0]           lt_symbol;
  logic                 at_cmd_received;
  logic                 at_rsp_received;
  logic [7:0]           at_addr;
  logic [6:0]           at_len;
  logic                 at_wr;
  logic [8*MAX_LEN-1:0] at_data;
  logic                 crc_error;
  logic                 frame_error;
  logic                 busy;

  // Symbol source / decoded-field consumer side
  modport master (
    output symbol, symbol_valid,
    input  lt_received, lt_symbol, at_cmd_received, at_rsp_received,
    input  at_addr, at_len, at_wr, at_data, crc_error, frame_error, busy
  );

  // Parser side
  modport slave (
    input  symbol, symbol_valid,
    output lt_received, lt_symbol, at_cmd_received, at_rsp_received,
    output at_addr, at_len, at_wr, at_data, crc_error, frame_error, busy
  );
endinterface

// File: rtl/sb_transactions_rx_fsm.sv
// Sideband receive transaction parser: decodes LT (DLE LSE CLSE) and
// DLE-stuffed AT frames (DLE STX addr len data crcH crcL DLE ETX),
// checks CRC-16 (poly 0x8005, init 0xFFFF, bytes fed LSB first).
module sb_transactions_rx_fsm #(
  parameter int MAX_LEN = 3,
  parameter int TIMEOUT = 64
) (
  input logic                      sb_clk,
  input logic                      rst,
  sb_transactions_rx_fsm_if.slave  bus
);
  localparam logic [7:0] DLE     = 8'hFE;
  localparam logic [7:0] STX_CMD = 8'h05;
  localparam logic [7:0] STX_RSP = 8'h04;
  localparam logic [7:0] ETX     = 8'h40;
  localparam int         TW      = $clog2(TIMEOUT + 1);
  localparam int         DW      = 8 * MAX_LEN;

  typedef enum logic [3:0] {
    S_IDLE, S_GOT_DLE, S_LT_CLSE, S_AT_ADDR, S_AT_LEN,
    S_AT_DATA, S_AT_CRC_H, S_AT_CRC_L, S_AT_DLE2, S_AT_ETX
  } state_t;

  state_t          state_reg, state_next;
  logic            esc_reg, esc_next;
  logic            is_rsp_reg, is_rsp_next;
  logic [7:0]      lse_reg, lse_next;
  logic [7:0]      addr_reg, addr_next;
  logic [6:0]      len_reg, len_next;
  logic            wr_reg, wr_next;
  logic [6:0]      cnt_reg, cnt_next;
  logic [6:0]      idx_reg, idx_next;
  logic [DW-1:0]   data_reg, data_next;
  logic [15:0]     crc_reg, crc_next;
  logic [7:0]      crc_h_reg, crc_h_next;
  logic [7:0]      crc_l_reg, crc_l_next;
  logic [TW-1:0]   tmo_reg, tmo_next;

  logic            lt_received_reg, lt_received_next;
  logic [7:0]      lt_symbol_reg, lt_symbol_next;
  logic            cmd_received_reg, cmd_received_next;
  logic            rsp_received_reg, rsp_received_next;
  logic [7:0]      at_addr_reg, at_addr_next;
  logic [6:0]      at_len_reg, at_len_next;
  logic            at_wr_reg, at_wr_next;
  logic [DW-1:0]   at_data_reg, at_data_next;
  logic            crc_error_reg, crc_error_next;
  logic            frame_error_reg, frame_error_next;

  logic            ev_lt, ev_ok, ev_crc, ev_ferr;
  logic            busy;
  logic [7:0]      b;
  logic            framing_bad;
  logic            has_data;
  logic [DW-1:0]   data_ins;

  assign b           = bus.symbol[8:1];
  assign framing_bad = bus.symbol[0] | ~bus.symbol[9];
  assign busy        = (state_reg != S_IDLE);
  // Length byte bit0 is the write flag; data follows only for write commands and read responses
  assign has_data    = is_rsp_reg ? ~b[0] : b[0];

  // One CRC-16 step per byte, data bits taken LSB first into an MSB-first register
  function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] d);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Byte-lane insert of the current data byte at position idx_reg
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_lane
      assign data_ins[gi*8 +: 8] = (idx_reg == 7'(gi)) ? b : data_reg[gi*8 +: 8];
    end
  endgenerate

  // State and datapath registers, async active-low reset
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= S_IDLE;
      esc_reg          <= 1'b0;
      is_rsp_reg       <= 1'b0;
      lse_reg          <= '0;
      addr_reg         <= '0;
      len_reg          <= '0;
      wr_reg           <= 1'b0;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      data_reg         <= '0;
      crc_reg          <= 16'hFFFF;
      crc_h_reg        <= '0;
      crc_l_reg        <= '0;
      tmo_reg          <= '0;
      lt_received_reg  <= 1'b0;
      lt_symbol_reg    <= '0;
      cmd_received_reg <= 1'b0;
      rsp_received_reg <= 1'b0;
      at_addr_reg      <= '0;
      at_len_reg       <= '0;
      at_wr_reg        <= 1'b0;
      at_data_reg      <= '0;
      crc_error_reg    <= 1'b0;
      frame_error_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      esc_reg          <= esc_next;
      is_rsp_reg       <= is_rsp_next;
      lse_reg          <= lse_next;
      addr_reg         <= addr_next;
      len_reg          <= len_next;
      wr_reg           <= wr_next;
      cnt_reg          <= cnt_next;
      idx_reg          <= idx_next;
      data_reg         <= data_next;
      crc_reg          <= crc_next;
      crc_h_reg        <= crc_h_next;
      crc_l_reg        <= crc_l_next;
      tmo_reg          <= tmo_next;
      lt_received_reg  <= lt_received_next;
      lt_symbol_reg    <= lt_symbol_next;
      cmd_received_reg <= cmd_received_next;
      rsp_received_reg <= rsp_received_next;
      at_addr_reg      <= at_addr_next;
      at_len_reg       <= at_len_next;
      at_wr_reg        <= at_wr_next;
      at_data_reg      <= at_data_next;
      crc_error_reg    <= crc_error_next;
      frame_error_reg  <= frame_error_next;
    end
  end

  // Next-state and frame datapath: parse one symbol per symbol_valid, run timeout otherwise
  always_comb begin
    state_next  = state_reg;
    esc_next    = esc_reg;
    is_rsp_next = is_rsp_reg;
    lse_next    = lse_reg;
    addr_next   = addr_reg;
    len_next    = len_reg;
    wr_next     = wr_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    data_next   = data_reg;
    crc_next    = crc_reg;
    crc_h_next  = crc_h_reg;
    crc_l_next  = crc_l_reg;
    tmo_next    = tmo_reg;
    ev_lt       = 1'b0;
    ev_ok       = 1'b0;
    ev_crc      = 1'b0;
    ev_ferr     = 1'b0;
    if (bus.symbol_valid) begin
      tmo_next = '0;
      if (busy && framing_bad) begin
        ev_ferr    = 1'b1;
        state_next = S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (b == DLE) state_next = S_GOT_DLE;
          end
          S_GOT_DLE: begin
            if (b[7]) begin
              lse_next   = b;
              state_next = S_LT_CLSE;
            end else if (b == STX_CMD || b == STX_RSP) begin
              is_rsp_next = (b == STX_RSP);
              crc_next    = crc_byte(16'hFFFF, b);
              state_next  = S_AT_ADDR;
            end else begin
              ev_ferr    = 1'b1;
              state_next = S_IDLE;
            end
          end
          S_LT_CLSE: begin
            if (b == ~lse_reg) ev_lt = 1'b1;
            else               ev_ferr = 1'b1;
            state_next = S_IDLE;
          end
          S_AT_DLE2: begin
            if (b == DLE) state_next = S_AT_ETX;
            else begin
              ev_ferr    = 1'b1;
              state_next = S_IDLE;
            end
          end
          S_AT_ETX: begin
            if (b != ETX)                          ev_ferr = 1'b1;
            else if (crc_reg == {crc_h_reg, crc_l_reg}) ev_ok = 1'b1;
            else                                   ev_crc = 1'b1;
            state_next = S_IDLE;
          end
          default: begin
            // Stuffed fields: a lone DLE arms the escape, DLE DLE yields one 0xFE byte
            if (!esc_reg && b == DLE) begin
              esc_next = 1'b1;
            end else if (esc_reg && b != DLE) begin
              ev_ferr    = 1'b1;
              state_next = S_IDLE;
            end else begin
              esc_next = 1'b0;
              case (state_reg)
                S_AT_ADDR: begin
                  addr_next  = b;
                  crc_next   = crc_byte(crc_reg, b);
                  state_next = S_AT_LEN;
                end
                S_AT_LEN: begin
                  len_next  = b[7:1];
                  wr_next   = b[0];
                  crc_next  = crc_byte(crc_reg, b);
                  idx_next  = '0;
                  data_next = '0;
                  cnt_next  = has_data ? b[7:1] : 7'd0;
                  if ((has_data && b[7:1] == 7'd0) || b[7:1] > 7'(MAX_LEN)) begin
                    ev_ferr    = 1'b1;
                    state_next = S_IDLE;
                  end else if (has_data) begin
                    state_next = S_AT_DATA;
                  end else begin
                    state_next = S_AT_CRC_H;
                  end
                end
                S_AT_DATA: begin
                  data_next = data_ins;
                  crc_next  = crc_byte(crc_reg, b);
                  idx_next  = idx_reg + 7'd1;
                  cnt_next  = cnt_reg - 7'd1;
                  if (cnt_reg == 7'd1) state_next = S_AT_CRC_H;
                end
                S_AT_CRC_H: begin
                  crc_h_next = b;
                  state_next = S_AT_CRC_L;
                end
                default: begin
                  crc_l_next = b;
                  state_next = S_AT_DLE2;
                end
              endcase
            end
          end
        endcase
      end
    end else if (busy) begin
      if (tmo_reg == TW'(TIMEOUT - 1)) begin
        ev_ferr    = 1'b1;
        state_next = S_IDLE;
        tmo_next   = '0;
      end else begin
        tmo_next = tmo_reg + 1'b1;
      end
    end
    if (state_next == S_IDLE) esc_next = 1'b0;
  end

  // Output pulses and field updates, registered one cycle after the final symbol
  always_comb begin
    lt_received_next  = ev_lt;
    lt_symbol_next    = ev_lt ? lse_reg : lt_symbol_reg;
    cmd_received_next = ev_ok & ~is_rsp_reg;
    rsp_received_next = ev_ok & is_rsp_reg;
    at_addr_next      = ev_ok ? addr_reg : at_addr_reg;
    at_len_next       = ev_ok ? len_reg : at_len_reg;
    at_wr_next        = ev_ok ? wr_reg : at_wr_reg;
    at_data_next      = ev_ok ? data_reg : at_data_reg;
    crc_error_next    = ev_crc;
    frame_error_next  = ev_ferr;
  end

  assign bus.lt_received     = lt_received_reg;
  assign bus.lt_symbol       = lt_symbol_reg;
  assign bus.at_cmd_received = cmd_received_reg;
  assign bus.at_rsp_received = rsp_received_reg;
  assign bus.at_addr         = at_addr_reg;
  assign bus.at_len          = at_len_reg;
  assign bus.at_wr           = at_wr_reg;
  assign bus.at_data         = at_data_reg;
  assign bus.crc_error       = crc_error_reg;
  assign bus.frame_error     = frame_error_reg;
  assign bus.busy            = busy;
endmodule

// File: tb/tb_sb_transactions_rx_fsm.sv
// Self-checking bench for sb_transactions_rx_fsm: directed plan cases plus
// randomized LT/AT frames checked against a frame-level reference model.
module tb_sb_transactions_rx_fsm;
  localparam int ML = 3;
  localparam logic [7:0] DLE = 8'hFE;
  localparam logic [7:0] ETX = 8'h40;
  localparam int K_LT = 1, K_CMD = 2, K_RSP = 3, K_CRC = 4, K_FERR = 5;

  logic sb_clk = 1'b0;
  logic rst    = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  // Expected visible fields (reference model state)
  logic [7:0]      exp_lt_symbol = '0;
  logic [7:0]      exp_addr      = '0;
  logic [6:0]      exp_len       = '0;
  logic            exp_wr        = 1'b0;
  logic [8*ML-1:0] exp_data      = '0;

  // Pulse counters for back-to-back checks
  int lt_seen = 0, cmd_seen = 0, rsp_seen = 0, crc_seen = 0, ferr_seen = 0;

  sb_transactions_rx_fsm_if #(.MAX_LEN(ML)) bus ();

  sb_transactions_rx_fsm #(.MAX_LEN(ML), .TIMEOUT(64)) dut (
    .sb_clk (sb_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sb_clk = ~sb_clk;

  // Count every output pulse, sampled away from the active edge
  always @(negedge sb_clk) begin
    if (bus.lt_received)     lt_seen++;
    if (bus.at_cmd_received) cmd_seen++;
    if (bus.at_rsp_received) rsp_seen++;
    if (bus.crc_error)       crc_seen++;
    if (bus.frame_error)     ferr_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC-16/0x8005, init FFFF, no final XOR, each byte shifted in LSB first
  function automatic logic [15:0] crc16(input logic [7:0] q[$]);
    logic [15:0] c;
    logic [7:0]  d;
    logic        fb;
    c = 16'hFFFF;
    foreach (q[k]) begin
      d = q[k];
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ d[0];
        c  = c << 1;
        if (fb) c = c ^ 16'h8005;
        d  = d >> 1;
      end
    end
    return c;
  endfunction

  task automatic send_raw(input logic [9:0] s);
    @(negedge sb_clk);
    bus.symbol       = s;
    bus.symbol_valid = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_raw({1'b1, v, 1'b0});
  endtask

  task automatic send_stuffed(input logic [7:0] v);
    if (v == DLE) send_byte(DLE);
    send_byte(v);
  endtask

  task automatic gap();
    @(negedge sb_clk);
    bus.symbol_valid = 1'b0;
    bus.symbol       = '0;
  endtask

  // Sends one AT frame and returns the outcome predicted from the frame rules
  task automatic send_at(input bit is_rsp, input logic [7:0] addr, input logic [6:0] len,
                         input bit wr, input logic [8*ML-1:0] data, input bit corrupt,
                         output int kind);
    logic [7:0]  body[$];
    logic [15:0] c;
    bit          has_data;
    int          cnt;
    has_data = (!is_rsp && wr) || (is_rsp && !wr);
    cnt      = has_data ? int'(len) : 0;
    body     = {};
    body.push_back(is_rsp ? 8'h04 : 8'h05);
    body.push_back(addr);
    body.push_back({len, wr});
    send_byte(DLE);
    send_byte(body[0]);
    send_stuffed(addr);
    send_stuffed({len, wr});
    if ((has_data && len == 7'd0) || int'(len) > ML) begin
      kind = K_FERR;
    end else begin
      for (int i = 0; i < cnt; i++) begin
        body.push_back(data[8*i +: 8]);
        send_stuffed(data[8*i +: 8]);
      end
      c = crc16(body);
      if (corrupt) c[0] = ~c[0];
      send_stuffed(c[15:8]);
      send_stuffed(c[7:0]);
      send_byte(DLE);
      send_byte(ETX);
      if (corrupt) begin
        kind = K_CRC;
      end else begin
        kind     = is_rsp ? K_RSP : K_CMD;
        exp_addr = addr;
        exp_len  = len;
        exp_wr   = wr;
        exp_data = '0;
        for (int i = 0; i < cnt; i++) exp_data[8*i +: 8] = data[8*i +: 8];
      end
    end
  endtask

  task automatic send_lt(input logic [7:0] lse, input logic [7:0] clse, output int kind);
    send_byte(DLE);
    send_byte(lse);
    send_byte(clse);
    if (clse == ~lse) begin
      kind          = K_LT;
      exp_lt_symbol = lse;
    end else begin
      kind = K_FERR;
    end
  endtask

  // Checks the pulse exactly one cycle after the last symbol, the fields, and pulse width
  task automatic finish_frame(input string tag, input int kind);
    gap();
    $display("frame %s kind=%0d lt=%0b cmd=%0b rsp=%0b crc=%0b ferr=%0b data=%0h", tag, kind,
             bus.lt_received, bus.at_cmd_received, bus.at_rsp_received, bus.crc_error,
             bus.frame_error, bus.at_data);
    check({tag, ".pulses"},
          {27'd0, bus.lt_received, bus.at_cmd_received, bus.at_rsp_received,
           bus.crc_error, bus.frame_error},
          {27'd0, kind == K_LT, kind == K_CMD, kind == K_RSP, kind == K_CRC, kind == K_FERR});
    check({tag, ".lt_symbol"}, 32'(bus.lt_symbol), 32'(exp_lt_symbol));
    check({tag, ".at_addr"},   32'(bus.at_addr),   32'(exp_addr));
    check({tag, ".at_len"},    32'(bus.at_len),    32'(exp_len));
    check({tag, ".at_wr"},     32'(bus.at_wr),     32'(exp_wr));
    check({tag, ".at_data"},   32'(bus.at_data),   32'(exp_data));
    check({tag, ".busy"},      32'(bus.busy),      32'd0);
    @(negedge sb_clk);
    check({tag, ".pulse_clr"},
          {27'd0, bus.lt_received, bus.at_cmd_received, bus.at_rsp_received,
           bus.crc_error, bus.frame_error}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".flags"},
          {26'd0, bus.lt_received, bus.at_cmd_received, bus.at_rsp_received,
           bus.crc_error, bus.frame_error, bus.busy}, 32'd0);
    check({tag, ".fields"}, {8'd0, bus.lt_symbol, bus.at_addr, bus.at_len, bus.at_wr}, 32'd0);
    check({tag, ".at_data"}, 32'(bus.at_data), 32'd0);
  endtask

  initial begin
    int          kind;
    int          b_lt, b_cmd, b_rsp, b_crc, b_ferr;
    logic [7:0]  lse, clse;
    logic [8*ML-1:0] rd;
    bus.symbol       = '0;
    bus.symbol_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge sb_clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge sb_clk);

    // 1. LT good, then LT with wrong complement
    send_lt(8'h80, 8'h7F, kind); finish_frame("lt_ok", kind);
    send_lt(8'h80, 8'h7E, kind); finish_frame("lt_bad", kind);

    // 2. Read command: no data, len=3
    send_at(1'b0, 8'h4E, 7'd3, 1'b0, 24'hABCDEF, 1'b0, kind); finish_frame("rd_cmd", kind);

    // 3. Read response, then same with corrupted CRC low byte
    send_at(1'b1, 8'h4E, 7'd3, 1'b0, 24'h332211, 1'b0, kind); finish_frame("rd_rsp", kind);
    send_at(1'b1, 8'h4E, 7'd3, 1'b0, 24'h998877, 1'b1, kind); finish_frame("rsp_crc", kind);

    // 4. Stuffed data byte, then a bad escape
    send_at(1'b1, 8'h4E, 7'd3, 1'b0, 24'h33FE11, 1'b0, kind); finish_frame("stuff", kind);
    send_byte(DLE); send_byte(8'h04); send_byte(8'h4E); send_byte(8'h06);
    send_byte(8'h11); send_byte(DLE); send_byte(8'h22);
    finish_frame("bad_esc", K_FERR);

    // Length boundaries: len > MAX_LEN, and zero-length write command
    send_at(1'b0, 8'h10, 7'd4, 1'b0, 24'h0, 1'b0, kind); finish_frame("len_big", kind);
    send_at(1'b0, 8'h10, 7'd0, 1'b1, 24'h0, 1'b0, kind); finish_frame("len_zero", kind);

    // 5. Timeout: exactly 64 idle cycles after the last symbol
    send_byte(DLE); send_byte(8'h05); send_byte(8'h4E);
    gap();
    repeat (63) @(negedge sb_clk);
    check("tmo.early_ferr", 32'(bus.frame_error), 32'd0);
    check("tmo.early_busy", 32'(bus.busy), 32'd1);
    @(negedge sb_clk);
    $display("timeout ferr=%0b busy=%0b", bus.frame_error, bus.busy);
    check("tmo.ferr", 32'(bus.frame_error), 32'd1);
    check("tmo.busy", 32'(bus.busy), 32'd0);
    @(negedge sb_clk);

    // Stop bit 0 mid-frame, then a clean LT
    send_byte(DLE); send_byte(8'h05); send_raw({1'b0, 8'h4E, 1'b0});
    finish_frame("stop0", K_FERR);
    send_lt(8'h80, 8'h7F, kind); finish_frame("lt_after", kind);

    // 6. Reset mid-frame, then a full response
    send_byte(DLE); send_byte(8'h04); send_byte(8'h4E);
    @(negedge sb_clk);
    bus.symbol_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    exp_lt_symbol = '0; exp_addr = '0; exp_len = '0; exp_wr = 1'b0; exp_data = '0;
    @(negedge sb_clk);
    rst = 1'b1;
    send_at(1'b1, 8'h4E, 7'd3, 1'b0, 24'h332211, 1'b0, kind); finish_frame("post_rst", kind);

    // Back-to-back frames, no idle gap
    b_lt = lt_seen; b_cmd = cmd_seen; b_rsp = rsp_seen; b_crc = crc_seen; b_ferr = ferr_seen;
    send_at(1'b1, 8'h21, 7'd2, 1'b0, 24'h00FE5A, 1'b0, kind);
    send_at(1'b0, 8'hFE, 7'd1, 1'b1, 24'h0000C3, 1'b0, kind);
    send_lt(8'hA5, 8'h5A, kind);
    gap();
    @(negedge sb_clk);
    $display("b2b lt=%0d cmd=%0d rsp=%0d crc=%0d ferr=%0d", lt_seen - b_lt, cmd_seen - b_cmd,
             rsp_seen - b_rsp, crc_seen - b_crc, ferr_seen - b_ferr);
    check("b2b.counts",
          32'((lt_seen - b_lt) * 10000 + (cmd_seen - b_cmd) * 1000 + (rsp_seen - b_rsp) * 100 +
              (crc_seen - b_crc) * 10 + (ferr_seen - b_ferr)), 32'd11100);
    check("b2b.addr", 32'(bus.at_addr), 32'(exp_addr));
    check("b2b.data", 32'(bus.at_data), 32'(exp_data));
    check("b2b.lt",   32'(bus.lt_symbol), 32'(exp_lt_symbol));

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        lse  = {1'b1, 7'($urandom)};
        clse = ~lse;
        if ($urandom_range(0, 3) == 0) clse = clse ^ (8'd1 << $urandom_range(0, 7));
        send_lt(lse, clse, kind);
        finish_frame("rnd_lt", kind);
      end else begin
        rd = 24'($urandom);
        if ($urandom_range(0, 3) == 0) rd[8*$urandom_range(0, ML-1) +: 8] = DLE;
        send_at(1'($urandom), 8'($urandom), 7'($urandom_range(0, 4)), 1'($urandom), rd,
                $urandom_range(0, 4) == 0, kind);
        finish_frame("rnd_at", kind);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
